mealy_1101: RTL and testbench

//   Serial bit-stream pattern detector for the sequence 1-1-0-1, with overlap.

---
 rtl/mealy_1101_pkg.sv | 22 ++
 rtl/mealy_1101.sv | 97 +++++++++
 tb/tb_mealy_1101.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mealy_1101_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mealy_1101_pkg
// Purpose  : Shared types and constants for the 1-1-0-1 serial pattern
//            detector.
//            - state_t : detector state, 2-bit encoded.
//            - PATTERN : the detected bit sequence, first bit in the MSB.
// Revision : 1.0 - initial release
// ============================================================================
package mealy_1101_pkg;

    typedef enum logic [1:0] {
        S0   = 2'd0,    // idle / no useful history
        S1   = 2'd1,    // seen "1"
        S11  = 2'd2,    // seen "11"
        S110 = 2'd3     // seen "110"
    } state_t;

    localparam logic [3:0] PATTERN = 4'b1101;

endpackage : mealy_1101_pkg
`default_nettype wire

// File: rtl/mealy_1101.sv
`default_nettype none
// ============================================================================
// Module   : mealy_1101
// Purpose  : Overlapping serial detector for the bit sequence 1-1-0-1.
//            Mealy machine: det is a combinational function of the current
//            state and the input bit, so det is high during the cycle in
//            which the final '1' of the pattern is on `in`.
// Ports    : clk      in   1        rising-edge clock
//            rst      in   1        asynchronous, active-high reset
//            in       in   1        serial data bit, sampled on rising clk
//            det      out  1        detect flag (state==S110 && in), low
//                                   while rst is high
//            det_cnt  out  COUNT_W  saturating detection count
//                                   (MEALY_1101_COUNT_EN builds only)
// Params   : COUNT_W  width of det_cnt (MEALY_1101_COUNT_EN builds only)
// Config   : MEALY_1101_COUNT_EN - when defined, adds the det_cnt counter and
//            port; det behaviour is the same in both builds.
// Revision : 1.0 - initial release
// ============================================================================
module mealy_1101
    import mealy_1101_pkg::*;
#(
    parameter int COUNT_W = 8
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in,
`ifdef MEALY_1101_COUNT_EN
    output logic [COUNT_W-1:0] det_cnt,
`endif
    output logic               det
);

    state_t state_q;
    state_t state_d;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and Mealy output.
    // S110 + '1' returns to S1 rather than S0 so the closing '1' of one match
    // can start the next (overlap). det is masked by rst because the state
    // register may not have settled to S0 yet in the same delta as rst rises.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = S0;
        det     = 1'b0;
        case (state_q)
            S0:      state_d = in ? S1  : S0;
            S1:      state_d = in ? S11 : S0;
            S11:     state_d = in ? S11 : S110;
            S110: begin
                state_d = in ? S1 : S0;
                det     = in & ~rst;
            end
            default: state_d = S0;
        endcase
    end

`ifdef MEALY_1101_COUNT_EN
    // ------------------------------------------------------------------------
    // Detection counter: counts clock edges on which det is high and holds
    // at all-ones once full.
    // ------------------------------------------------------------------------
    logic [COUNT_W-1:0] det_cnt_q;
    logic [COUNT_W-1:0] det_cnt_d;

    always_comb begin
        det_cnt_d = det_cnt_q;
        if (det && (det_cnt_q != {COUNT_W{1'b1}})) begin
            det_cnt_d = det_cnt_q + {{(COUNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            det_cnt_q <= '0;
        end else begin
            det_cnt_q <= det_cnt_d;
        end
    end

    assign det_cnt = det_cnt_q;
`endif

endmodule : mealy_1101
`default_nettype wire

// File: tb/tb_mealy_1101.sv
`default_nettype none
// ============================================================================
// Module   : tb_mealy_1101
// Purpose  : Self-checking bench for mealy_1101. A reference model keeps the
//            bits sampled since the last reset and flags a detect whenever the
//            last three sampled bits followed by the live input spell PATTERN.
//            Directed sequences are followed by a long random bit stream with
//            occasional asynchronous reset pulses.
// Config   : MEALY_1101_COUNT_EN - also checks det_cnt with COUNT_W = 2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mealy_1101;
    import mealy_1101_pkg::*;

    localparam int c_COUNT_W = 2;
    localparam int c_CNT_MAX = (1 << c_COUNT_W) - 1;

    logic clk;
    logic rst;
    logic tb_in;
    logic det;
`ifdef MEALY_1101_COUNT_EN
    logic [c_COUNT_W-1:0] det_cnt;
`endif

    int n_total;
    int n_bad;
    int det_seen;

    // Reference model state
    bit hist[$];       // bits sampled since reset, newest at the back
    int model_cnt;

    mealy_1101 #(.COUNT_W(c_COUNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .in      (tb_in),
`ifdef MEALY_1101_COUNT_EN
        .det_cnt (det_cnt),
`endif
        .det     (det)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Detect if the newest three sampled bits plus the live bit equal PATTERN.
    function automatic logic model_det(input bit b);
        logic [3:0] win;
        if (hist.size() < 3) return 1'b0;
        win = {hist[hist.size()-3], hist[hist.size()-2], hist[hist.size()-1], b};
        return (win == PATTERN);
    endfunction

    // Clock edge in the model: count a detect, then record the sampled bit.
    task automatic model_step(input bit b);
        if (model_det(b) && model_cnt < c_CNT_MAX) model_cnt++;
        hist.push_back(b);
        if (hist.size() > 3) void'(hist.pop_front());
    endtask

    task automatic model_clear();
        hist.delete();
        model_cnt = 0;
    endtask

    task automatic chk_cnt(input string tag);
`ifdef MEALY_1101_COUNT_EN
        chk(tag, 32'(det_cnt), 32'(model_cnt));
`endif
    endtask

    // Entered 3 time units before a rising edge; returns at the same phase
    // one cycle later. det is probed twice before the edge (also with the
    // input flipped, to exercise the zero-latency path) and once after.
    task automatic drive_bit(input bit b);
        tb_in = b;
        #1;
        if (det === 1'b1) det_seen++;
        chk("det_pre", 32'(det), 32'(model_det(b)));
        tb_in = ~b;
        #1;
        chk("det_flip", 32'(det), 32'(model_det(~b)));
        tb_in = b;
        @(posedge clk);
        model_step(b);
        #1;
        chk("det_post", 32'(det), 32'(model_det(b)));
        chk_cnt("det_cnt");
        #6;
    endtask

    // Asynchronous reset pulse between edges while the input is '1'.
    task automatic reset_pulse();
        rst   = 1'b1;
        tb_in = 1'b1;
        #1;
        chk("det_in_rst", 32'(det), 32'd0);
        chk_cnt("cnt_in_rst");
        rst = 1'b0;
        model_clear();
        #1;
        chk("det_after_rst", 32'(det), 32'd0);
        @(posedge clk);
        model_step(1'b1);
        #7;
    endtask

    // Feed len bits MSB-first and compare the number of observed detects.
    task automatic run_seq(input string tag, input logic [15:0] v, input int len, input int exp_dets);
        drive_bit(1'b0);
        drive_bit(1'b0);
        det_seen = 0;
        for (int i = len - 1; i >= 0; i--) drive_bit(v[i]);
        chk(tag, 32'(det_seen), 32'(exp_dets));
    endtask

    initial begin
        n_total  = 0;
        n_bad    = 0;
        det_seen = 0;
        model_clear();
        rst   = 1'b1;
        tb_in = 1'b0;

        // Reset window
        #3;
        chk("rst_det_a", 32'(det), 32'd0);
        chk_cnt("rst_cnt");
        #4;
        chk("rst_det_b", 32'(det), 32'd0);
        #5;                       // t = 12
        rst = 1'b0;

        // Basic match: 1@22, 1@32, 0@42, 1@52
        drive_bit(1'b0);
        det_seen = 0;
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        chk("basic_dets", 32'(det_seen), 32'd1);

        run_seq("overlap_dets", 16'b1101101, 7, 2);
        run_seq("near_11101",   16'b11101,   5, 1);
        run_seq("near_10101",   16'b10101,   5, 0);

        // Reset mid-pattern: 1,1,0 then async pulse, then in=1
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        reset_pulse();
        drive_bit(1'b0);
        drive_bit(1'b1);

        // Back-to-back overlapping matches (saturates a 2-bit counter)
        reset_pulse();
        run_seq("five_matches", 16'b1101101101101101, 16, 5);
`ifdef MEALY_1101_COUNT_EN
        chk("cnt_saturated", 32'(det_cnt), 32'(c_CNT_MAX));
`endif
        reset_pulse();
        chk_cnt("cnt_cleared");

        // Random stream, biased towards '1' so matches are frequent
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) reset_pulse();
            else drive_bit($urandom_range(0, 99) < 60);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_mealy_1101
`default_nettype wire
